store_align_unit: RTL

//   Write-side counterpart of the load-path sign/zero extension: narrows a 32-bit store

---
 rtl/store_align_unit_pkg.sv | 40 ++++
 rtl/store_lane_shifter.sv | 44 ++++
 rtl/store_align_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/store_align_unit_pkg.sv
// ----------------------------------------------------------------------------
// store_align_unit_pkg
//   Shared types and constants for the store alignment path.
//   - mem_size_e : store access width as encoded on st_size
//   - st_state_e : state encoding of the store sequencer
//   - LANES      : byte lanes on the data-memory bus
//   - size_mask  : contiguous byte mask for an access width (0 for reserved)
// ----------------------------------------------------------------------------
package store_align_unit_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        MEM_B    = 2'b00,
        MEM_H    = 2'b01,
        MEM_W    = 2'b10,
        MEM_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BEAT0 = 3'd1,
        BEAT1 = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } st_state_e;

    // Contiguous low-order byte mask, (1 << nbytes) - 1.
    function automatic logic [LANES-1:0] size_mask(input mem_size_e size);
        logic [LANES-1:0] mask;
        case (size)
            MEM_B:   mask = 4'b0001;
            MEM_H:   mask = 4'b0011;
            MEM_W:   mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/store_lane_shifter.sv
// ----------------------------------------------------------------------------
// store_lane_shifter
//   Combinational lane math for one store. The narrowed operand and its byte
//   mask are shifted across an 8-lane (two-word) window so that a store that
//   crosses a word boundary shows up as lanes 4..7.
//   Ports:
//     size_i     access width
//     off_i      byte offset within the word (addr[1:0])
//     data_i     store operand, low 8/16/32 bits used
//     be8_o      byte enables over the two-word window
//     data64_o   lane-shifted data over the two-word window
//     split_o    store touches the second word
//     size_err_o reserved width requested
// ----------------------------------------------------------------------------
module store_lane_shifter
    import store_align_unit_pkg::*;
(
    input  mem_size_e   size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] data_i,
    output logic [7:0]  be8_o,
    output logic [63:0] data64_o,
    output logic        split_o,
    output logic        size_err_o
);

    logic [31:0] narrow;

    always_comb begin
        narrow = 32'd0;
        case (size_i)
            MEM_B:   narrow = {24'd0, data_i[7:0]};
            MEM_H:   narrow = {16'd0, data_i[15:0]};
            MEM_W:   narrow = data_i;
            default: narrow = 32'd0;
        endcase
    end

    assign be8_o      = {4'd0, size_mask(size_i)} << off_i;
    assign data64_o   = {32'd0, narrow} << {off_i, 3'b000};
    assign split_o    = |be8_o[7:4];
    assign size_err_o = (size_i == MEM_RSVD);

endmodule

// File: rtl/store_align_unit.sv
// ----------------------------------------------------------------------------
// store_align_unit
//   Narrows a store operand to byte/half/word, places it on the correct byte
//   lanes of a word-addressed bus and issues one or two bus beats. A store
//   that crosses a word boundary is split into two beats (or rejected when
//   ALLOW_MISALIGNED is 0).
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     st_valid/st_ready          store request handshake
//     st_addr/st_data/st_size    request payload
//     st_done                    pulse: store fully written
//     st_err                     pulse: store rejected, no bus traffic
//     mem_req/mem_gnt            bus beat handshake
//     mem_addr/mem_wdata/mem_be  bus beat payload (zero when no beat)
// ----------------------------------------------------------------------------
module store_align_unit
    import store_align_unit_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            st_valid,
    output logic            st_ready,
    input  logic [XLEN-1:0] st_addr,
    input  logic [XLEN-1:0] st_data,
    input  logic [1:0]      st_size,
    output logic            st_done,
    output logic            st_err,
    output logic            mem_req,
    input  logic            mem_gnt,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [LANES-1:0] mem_be
);

    st_state_e state_q, state_d;

    // Captured request, already in lane form.
    logic [XLEN-3:0] word_q;
    logic [7:0]      be8_q;
    logic [63:0]     data64_q;
    logic            split_q;

    logic [7:0]  sh_be8;
    logic [63:0] sh_data64;
    logic        sh_split;
    logic        sh_size_err;

    store_lane_shifter u_shifter (
        .size_i     (mem_size_e'(st_size)),
        .off_i      (st_addr[1:0]),
        .data_i     (st_data),
        .be8_o      (sh_be8),
        .data64_o   (sh_data64),
        .split_o    (sh_split),
        .size_err_o (sh_size_err)
    );

    logic accept;
    logic reject;

    assign accept = st_valid && (state_q == IDLE);
    assign reject = sh_size_err || (sh_split && !ALLOW_MISALIGNED);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = reject ? ERR : BEAT0;
            BEAT0: if (mem_gnt) state_d = split_q ? BEAT1 : DONE;
            BEAT1: if (mem_gnt) state_d = DONE;
            DONE:  state_d = IDLE;
            ERR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            word_q   <= '0;
            be8_q    <= '0;
            data64_q <= '0;
            split_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept && !reject) begin
                word_q   <= st_addr[XLEN-1:2];
                be8_q    <= sh_be8;
                data64_q <= sh_data64;
                split_q  <= sh_split;
            end
        end
    end

    // Payload is decoded from registered state only, so it cannot move while
    // a beat waits for its grant. The +1 on the word index wraps at the top of
    // the address space.
    always_comb begin
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        case (state_q)
            BEAT0: begin
                mem_req   = 1'b1;
                mem_addr  = {word_q, 2'b00};
                mem_wdata = data64_q[31:0];
                mem_be    = be8_q[3:0];
            end
            BEAT1: begin
                mem_req   = 1'b1;
                mem_addr  = {word_q + 1'b1, 2'b00};
                mem_wdata = data64_q[63:32];
                mem_be    = be8_q[7:4];
            end
            default: ;
        endcase
    end

    assign st_ready = (state_q == IDLE);
    assign st_done  = (state_q == DONE);
    assign st_err   = (state_q == ERR);

endmodule
